// File: rtl/fft_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_tx
// Brief    : Ping-pong buffered framer emitting contiguous FFT_LEN-sample
//            bursts with forced idle gaps. Optional short-frame zero padding
//            is enabled by defining FFT_TX_ZERO_PAD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fft_frame_tx #(
   parameter int DATA_WID     = 16,
   parameter int FFT_LEN      = 16,
   parameter int LOG2_FFT_LEN = 4,
   parameter int GAP_CYCLES   = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DATA_WID-1:0] s_data_re,
   input  logic [DATA_WID-1:0] s_data_im,
   input  logic                s_valid,
   output logic                s_ready,
`ifdef FFT_TX_ZERO_PAD_EN
   input  logic                s_last,
`endif
   output logic [DATA_WID-1:0] m_data_re,
   output logic [DATA_WID-1:0] m_data_im,
   output logic                m_val,
   output logic [15:0]         frame_cnt
);

   localparam int                      c_gap_w    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [LOG2_FFT_LEN-1:0] c_cnt_last = LOG2_FFT_LEN'(FFT_LEN - 1);
   localparam logic [LOG2_FFT_LEN-1:0] c_cnt_one  = LOG2_FFT_LEN'(1);
   localparam logic [c_gap_w-1:0]      c_gap_last = c_gap_w'(GAP_CYCLES - 1);
   localparam logic [c_gap_w-1:0]      c_gap_one  = c_gap_w'(1);

   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_burst = 2'd1;
   localparam logic [1:0] c_st_gap   = 2'd2;

   // Sample storage: {bank, slot} addressed, re in the upper half
   logic [2*DATA_WID-1:0]   r_mem [0:2*FFT_LEN-1];

   logic                    r_wr_bank;
   logic [LOG2_FFT_LEN-1:0] r_wr_cnt;
   logic [1:0]              r_full;
   logic                    w_wr_xfer;
   logic                    w_wr_en;
   logic                    w_wr_done;
   logic [2*DATA_WID-1:0]   w_wr_data;
   logic [1:0]              w_full_set;
   logic [1:0]              w_full_clr;

   logic [1:0]              r_state;
   logic [1:0]              w_state_nxt;
   logic                    r_rd_bank;
   logic [LOG2_FFT_LEN-1:0] r_rd_cnt;
   logic [c_gap_w-1:0]      r_gap_cnt;
   logic                    w_burst_act;
   logic                    w_burst_done;
   logic                    w_gap_act;
   logic                    w_gap_done;
   logic                    r_m_val;
   logic [2*DATA_WID-1:0]   r_m_data;
   logic [15:0]             r_frame_cnt;

   assign w_wr_xfer = s_valid & s_ready;

`ifdef FFT_TX_ZERO_PAD_EN
   // PAD fills the rest of a short frame with zeros while the input is held off
   logic r_pad;
   logic w_pad_start;

   assign w_pad_start = w_wr_xfer & s_last & (r_wr_cnt != c_cnt_last);
   assign s_ready     = ~r_full[r_wr_bank] & ~r_pad;
   assign w_wr_en     = w_wr_xfer | r_pad;
   assign w_wr_data   = r_pad ? '0 : {s_data_re, s_data_im};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pad <= 1'b0;
      end else if (w_pad_start) begin
         r_pad <= 1'b1;
      end else if (w_wr_done) begin
         r_pad <= 1'b0;
      end
   end
`else
   assign s_ready   = ~r_full[r_wr_bank];
   assign w_wr_en   = w_wr_xfer;
   assign w_wr_data = {s_data_re, s_data_im};
`endif

   assign w_wr_done = w_wr_en & (r_wr_cnt == c_cnt_last);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_bank <= 1'b0;
         r_wr_cnt  <= '0;
      end else if (w_wr_en) begin
         if (w_wr_done) begin
            r_wr_cnt  <= '0;
            r_wr_bank <= ~r_wr_bank;
         end else begin
            r_wr_cnt  <= r_wr_cnt + c_cnt_one;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[{r_wr_bank, r_wr_cnt}] <= w_wr_data;
      end
   end

   // Set and clear always target different banks, so both may act on one edge
   for (genvar b = 0; b < 2; b++) begin : g_bank
      assign w_full_set[b] = w_wr_done    & (int'(r_wr_bank) == b);
      assign w_full_clr[b] = w_burst_done & (int'(r_rd_bank) == b);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_full <= 2'b00;
      end else begin
         r_full <= (r_full & ~w_full_clr) | w_full_set;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle:  if (r_full[r_rd_bank]) w_state_nxt = c_st_burst;
         c_st_burst: if (w_burst_done)      w_state_nxt = c_st_gap;
         c_st_gap:   if (w_gap_done)        w_state_nxt = c_st_idle;
         default:                           w_state_nxt = c_st_idle;
      endcase
   end

   always_comb begin
      w_burst_act  = 1'b0;
      w_burst_done = 1'b0;
      w_gap_act    = 1'b0;
      w_gap_done   = 1'b0;
      case (r_state)
         c_st_burst: begin
            w_burst_act  = 1'b1;
            w_burst_done = (r_rd_cnt == c_cnt_last);
         end
         c_st_gap: begin
            w_gap_act    = 1'b1;
            w_gap_done   = (r_gap_cnt == c_gap_last);
         end
         default: ;
      endcase
   end

   // Output data is forced to zero in every non-burst cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_bank   <= 1'b0;
         r_rd_cnt    <= '0;
         r_gap_cnt   <= '0;
         r_m_val     <= 1'b0;
         r_m_data    <= '0;
         r_frame_cnt <= '0;
      end else begin
         if (w_burst_act) begin
            r_m_val  <= 1'b1;
            r_m_data <= r_mem[{r_rd_bank, r_rd_cnt}];
            r_rd_cnt <= r_rd_cnt + c_cnt_one;
         end else begin
            r_m_val  <= 1'b0;
            r_m_data <= '0;
         end
         if (w_burst_done) begin
            r_rd_bank   <= ~r_rd_bank;
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
         if (w_gap_act) begin
            r_gap_cnt <= r_gap_cnt + c_gap_one;
         end else begin
            r_gap_cnt <= '0;
         end
      end
   end

   assign m_val     = r_m_val;
   assign m_data_re = r_m_data[2*DATA_WID-1:DATA_WID];
   assign m_data_im = r_m_data[DATA_WID-1:0];
   assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: doc/fft_frame_tx.md
# fft_frame_tx

Streaming frame transmitter for the serial input side of the FFT top level. Accepts complex samples from an upstream source over a valid/ready handshake and buffers them in a ping-pong pair of frame banks. Emits each full frame as one contiguous burst of exactly FFT_LEN samples with the valid line held high throughout, and forces idle cycles between bursts. This is the framing the FFT serial-to-parallel input stage requires, since that stage restarts its sample counter whenever valid drops.

## Interface
Parameters:
- DATA_WID, 16: bit width of each real/imag sample.
- FFT_LEN, 16: samples per frame; power of two, ≥ 4.
- LOG2_FFT_LEN, 4: log2(FFT_LEN).
- GAP_CYCLES, 1: minimum idle cycles (m_val=0) between bursts; ≥ 1.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_data_re  in  DATA_WID  upstream sample, real part.
- s_data_im  in  DATA_WID  upstream sample, imag part.
- s_valid  in  1  upstream sample valid.
- s_ready  out  1  block can accept a sample; a transfer occurs when s_valid & s_ready.
- s_last  in  1  marks the final sample of a short frame. Present only with FFT_TX_ZERO_PAD_EN.
- m_data_re  out  DATA_WID  burst sample, real part; drives the FFT input real data.
- m_data_im  out  DATA_WID  burst sample, imag part.
- m_val  out  1  burst valid; drives the FFT input valid.
- frame_cnt  out  16  count of bursts completed; wraps modulo 2^16.

## Operation
- Storage is two banks (0/1), each holding FFT_LEN complex samples. Each bank has a full flag.
- Write side state: wr_bank, wr_cnt (LOG2_FFT_LEN bits).
  - s_ready = !full[wr_bank], decoded from registers only. There is no combinational path from s_valid.
  - On each transfer, the sample is written to bank[wr_bank][wr_cnt] and wr_cnt increments.
  - On the transfer at wr_cnt == FFT_LEN-1: set full[wr_bank], set wr_cnt to 0, toggle wr_bank.
- Read FSM states: IDLE, BURST, GAP.
  - IDLE: if full[rd_bank] is set, go to BURST with rd_cnt=0.
  - BURST: each cycle, register bank[rd_bank][rd_cnt] onto m_data_*, set m_val=1, increment rd_cnt.
  - At rd_cnt == FFT_LEN-1: clear full[rd_bank], toggle rd_bank, increment frame_cnt, go to GAP.
  - GAP: m_val=0 and m_data_*=0 for GAP_CYCLES cycles, then go to IDLE.
- A burst is never interrupted. m_val stays high for exactly FFT_LEN consecutive cycles.
- The write and read sides always reference different banks when both flags change on the same edge. Set and clear are independent bits, and both take effect.
- Whenever m_val=0, m_data_* are driven to 0.

## Timing
- Reset values: s_ready=1 (both banks empty), m_val=0, m_data_re=m_data_im=0, frame_cnt=0. FSM resets to IDLE; wr_bank=rd_bank=0, counters=0.
- rst asserted mid-frame or mid-burst: all outputs return to reset values asynchronously, and any partial or buffered frames are discarded. The first transfer after reset lands in bank 0, slot 0.
- Latency: the last sample of a frame is accepted on edge E. IDLE sees the full flag after edge E, and the first m_val=1 cycle begins after edge E+2.
- Bank release: the bank becomes writable (s_ready rises if it was stalled) in the cycle after the edge that outputs its last sample.
- Minimum burst spacing is FFT_LEN + GAP_CYCLES + 1 cycles (start to start), including one IDLE cycle.
- Sustained input at one sample per cycle:
  - s_ready deasserts periodically.
  - Throughput is FFT_LEN / (FFT_LEN + GAP_CYCLES + 1) samples per cycle.
  - No sample is ever dropped.

## Configuration
- FFT_TX_ZERO_PAD_EN defined:
  - The s_last port exists.
  - A transfer with s_last=1 at wr_cnt < FFT_LEN-1 enters a PAD sub-state. PAD writes zeros (re=im=0) into the remaining slots, one per cycle, with s_ready=0. It then marks the bank full exactly as a normal frame completion would.
  - A transfer with s_last=1 at wr_cnt == FFT_LEN-1 behaves as a normal completion.
- Macro undefined: no s_last port and no PAD logic. Frames complete only on the FFT_LEN-th sample.

## Test plan
- Reset check: hold rst=1 → s_ready=1, m_val=0, m_data_*=0, frame_cnt=0.
- Single frame: send FFT_LEN=16 samples re=k, im=-k (k=0..15) back-to-back → 2 cycles after the last accept, m_val is high for exactly 16 cycles with re=0..15, im=0..-15, in order. Then m_val=0 and frame_cnt=1.
- Backpressure: stream 64 samples with s_valid tied high → s_ready drops while both banks are full. Output shows 4 bursts of 16, each followed by ≥1 idle cycle, no loss or reorder. frame_cnt=4.
- GAP_CYCLES=3: two queued frames → exactly 3 m_val=0 cycles plus 1 IDLE cycle between bursts.
- Mid-burst reset: assert rst at burst sample 7 → m_val=0 immediately. After release, a fresh 16-sample frame is output intact and frame_cnt restarts from 1.
- With FFT_TX_ZERO_PAD_EN: send 5 samples (values 1..5) with s_last on the 5th → s_ready is low for 11 cycles, then the burst outputs 1..5 followed by 11 zeros.
